traffic_phase_scheduler: RTL and testbench
==========================================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter TL, default 16: long interval in cycles, the minimum highway-green and maximum farm-green time; range 1..255.
REQ-002 Parameter TS, default 4: short interval in cycles, the yellow time; range 1..255.
REQ-003 Parameter TW, default 8: pedestrian walk interval in cycles; range 1..255.
REQ-004 Clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 C  input  1  a car is waiting on the farm road; level input, synchronous to Clk.
REQ-007 PED  input  1  pedestrian crossing request; pulse or level input.
REQ-008 AMB  input  1  ambulance preemption in favour of the highway; level input.
REQ-009 HR, HY, HG  output  1 each  highway red, yellow and green lamps.
REQ-010 FR, FY, FG  output  1 each  farm road red, yellow and green lamps.
REQ-011 WALK  output  1  pedestrian walk lamp.
REQ-012 PP  output  1  a pedestrian request is pending.
REQ-013 STATE  output  3  current phase code.

Function
REQ-014 Phases and codes SHALL be: S_HG=000 (HG, FR), S_HY=001 (HY, FR), S_FG=010 (HR, FG), S_FY=011 (HR, FY), S_PW=100 (HR, FR, WALK).
REQ-015 All lamp outputs and WALK SHALL be decoded from the state register only (Moore decode); exactly one highway lamp and one farm lamp SHALL be lit in every state.
REQ-016 An internal 8-bit interval down-counter SHALL be loaded with N-1 on every state entry (N = TL, TS, TL, TS, TW for HG, HY, FG, FY, PW), decrement by 1 each cycle, and saturate at 0.
REQ-017 "Expired" SHALL mean counter==0; a state whose exit condition depends only on expiry therefore lasts exactly N cycles.
REQ-018 S_HG -> S_HY SHALL occur when the timer has expired AND (C OR PP) AND AMB==0; otherwise remain in S_HG with the counter held at 0.
REQ-019 S_HY -> S_PW on expiry if PP==1; otherwise S_HY -> S_FG on expiry. The pedestrian request SHALL win over C.
REQ-020 S_FG -> S_FY SHALL occur on expiry, OR when C==0, OR when AMB==1, whichever occurs first; the transition happens on the next edge.
REQ-021 S_FY -> S_HG on expiry.
REQ-022 S_PW -> S_HG on expiry, OR on the next edge after AMB==1 (abort).
REQ-023 PP SHALL be set on any edge where PED==1 and the state is not S_PW.
REQ-024 PP SHALL be cleared on the S_PW -> S_HG transition caused by expiry.
REQ-025 PED SHALL be ignored while in S_PW.
REQ-026 On an AMB abort of S_PW, PP SHALL remain set so the request is served later.
REQ-027 If set and clear of PP coincide, set SHALL win; this can only occur on a non-PW edge, so it is moot by construction.
REQ-028 AMB in S_HY SHALL NOT alter the yellow: S_HY completes normally, and S_FG then exits on its next edge per REQ-020.
REQ-029 If C and PP are both pending, the order SHALL be HG -> HY -> PW -> HG (full TL) -> HY -> FG.

Reset
REQ-030 While reset==0 the block SHALL immediately, without waiting for Clk: set state S_HG, load the counter with TL-1, clear PP, drive HG=FR=1 and all other lamps and WALK to 0, and drive STATE=000.
REQ-031 Reset asserted mid-phase SHALL abandon that phase without passing through yellow.
REQ-032 The first edge after reset release SHALL begin counting the S_HG interval.

Verification
REQ-033 Release reset with C=PED=AMB=0 and run 100 cycles -> STATE stays 000, HG=FR=1, PP=0 throughout.
REQ-034 Hold C=1 from reset with default parameters -> HG for 16 cycles, HY 4, FG 16, FY 4, then back to HG; the lamps are one-hot per road in every cycle.
REQ-035 Pulse PED for one cycle at cycle 3 with C=0 -> PP=1 from cycle 4; HY during cycles 16-19; PW during cycles 20-27 with WALK=1 and HR=FR=1; HG from cycle 28 with PP=0.
REQ-036 With C=1, assert AMB at FG cycle 5 -> FY on the next edge for 4 cycles, then HG; with AMB held, HG stays past expiry.
REQ-037 Assert AMB at cycle 2 of PW -> WALK=0 and STATE=000 next edge, PP remains 1; drop AMB -> the PW phase is served after the next HG/HY sequence.
REQ-038 Assert reset low mid-FY, asynchronously between edges -> HG=FR=1, FY=0, PP=0 and STATE=000 immediately, before the next Clk edge.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: highway / farm-road intersection controller with a
// pedestrian walk phase and ambulance preemption in favour of the highway.
// All lamps are a Moore decode of the phase register; a single 8-bit
// down-counter times every phase.

module traffic_phase_scheduler #(
    parameter int unsigned TL = 16,  // highway-green minimum, farm-green maximum
    parameter int unsigned TS = 4,   // yellow time
    parameter int unsigned TW = 8    // pedestrian walk time
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       C,
    input  logic       PED,
    input  logic       AMB,
    output logic       HR,
    output logic       HY,
    output logic       HG,
    output logic       FR,
    output logic       FY,
    output logic       FG,
    output logic       WALK,
    output logic       PP,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_HG = 3'b000,
        S_HY = 3'b001,
        S_FG = 3'b010,
        S_FY = 3'b011,
        S_PW = 3'b100
    } phase_t;

    phase_t     state;
    phase_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       pp_q;
    logic       pp_nxt;
    logic       expired;
    logic       pp_set;
    logic       pp_clr;

    // Counter reload value for a phase: its duration minus one, so a phase
    // that exits only on expiry lasts exactly its nominal number of cycles.
    function automatic logic [7:0] reload(input phase_t p);
        case (p)
            S_HG:    reload = 8'(TL - 1);
            S_HY:    reload = 8'(TS - 1);
            S_FG:    reload = 8'(TL - 1);
            S_FY:    reload = 8'(TS - 1);
            S_PW:    reload = 8'(TW - 1);
            default: reload = 8'(TL - 1);
        endcase
    endfunction

    assign expired = (cnt == 8'd0);

    // Phase register, interval counter and pending-pedestrian flag.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational blocks.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= S_HG;
            cnt   <= 8'(TL - 1);
            pp_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pp_q  <= pp_nxt;
        end
    end

    // Next-phase selection.
    // NOTE: state_nxt is given a default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            // Highway keeps green until the minimum has elapsed and someone is
            // waiting; an ambulance holds the highway green indefinitely.
            S_HG: if (expired && (C || pp_q) && !AMB) state_nxt = S_HY;
            // A pending pedestrian is served before the farm road.
            S_HY: if (expired) state_nxt = pp_q ? S_PW : S_FG;
            // Farm green ends on timeout, an empty farm road, or an ambulance.
            S_FG: if (expired || !C || AMB) state_nxt = S_FY;
            S_FY: if (expired) state_nxt = S_HG;
            // An ambulance aborts the walk straight to highway green.
            S_PW: if (expired || AMB) state_nxt = S_HG;
            default: state_nxt = S_HG;
        endcase
    end

    // Interval counter: reload on every phase change, otherwise count down
    // and stick at zero (HG relies on this while it waits for traffic).
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = reload(state_nxt);
        end else if (!expired) begin
            cnt_nxt = cnt - 8'd1;
        end
    end

    // Pedestrian request: latched outside the walk phase, released only when
    // the walk is served to completion so an aborted walk is retried later.
    always_comb begin
        pp_set = PED && (state != S_PW);
        pp_clr = (state == S_PW) && expired;
        pp_nxt = pp_set || (pp_q && !pp_clr);
    end

    // Lamp decode from the phase register only.
    always_comb begin
        HR   = 1'b0;
        HY   = 1'b0;
        HG   = 1'b0;
        FR   = 1'b0;
        FY   = 1'b0;
        FG   = 1'b0;
        WALK = 1'b0;
        case (state)
            S_HG: begin HG = 1'b1; FR = 1'b1; end
            S_HY: begin HY = 1'b1; FR = 1'b1; end
            S_FG: begin HR = 1'b1; FG = 1'b1; end
            S_FY: begin HR = 1'b1; FY = 1'b1; end
            S_PW: begin HR = 1'b1; FR = 1'b1; WALK = 1'b1; end
            default: begin HG = 1'b1; FR = 1'b1; end
        endcase
    end

    assign PP    = pp_q;
    assign STATE = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed table and hand sequences for
// the documented scenarios, then random stimulus against a phase/elapsed-time
// reference model.

module tb_traffic_phase_scheduler;

    localparam int P_TL = 16;
    localparam int P_TS = 4;
    localparam int P_TW = 8;

    localparam logic [2:0] ST_HG = 3'd0;
    localparam logic [2:0] ST_HY = 3'd1;
    localparam logic [2:0] ST_FG = 3'd2;
    localparam logic [2:0] ST_FY = 3'd3;
    localparam logic [2:0] ST_PW = 3'd4;

    logic       Clk;
    logic       reset;
    logic       C;
    logic       PED;
    logic       AMB;
    logic       HR, HY, HG, FR, FY, FG, WALK, PP;
    logic [2:0] STATE;
    logic [6:0] lamps;

    int total = 0;
    int bad   = 0;

    // Reference model: current phase, cycles spent in it, pending flag.
    int m_phase;
    int m_elapsed;
    bit m_pp;

    typedef struct {
        bit         c;
        bit         ped;
        bit         amb;
        int         n;
        logic [2:0] st;
        bit         pp;
    } vec_t;

    vec_t tbl[5];

    traffic_phase_scheduler #(.TL(P_TL), .TS(P_TS), .TW(P_TW)) dut (
        .Clk   (Clk),
        .reset (reset),
        .C     (C),
        .PED   (PED),
        .AMB   (AMB),
        .HR    (HR),
        .HY    (HY),
        .HG    (HG),
        .FR    (FR),
        .FY    (FY),
        .FG    (FG),
        .WALK  (WALK),
        .PP    (PP),
        .STATE (STATE)
    );

    assign lamps = {HR, HY, HG, FR, FY, FG, WALK};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {HR,HY,HG,FR,FY,FG,WALK} for each phase code.
    function automatic logic [6:0] lamp_of(input int p);
        case (p)
            0:       lamp_of = 7'b0011000;
            1:       lamp_of = 7'b0101000;
            2:       lamp_of = 7'b1000010;
            3:       lamp_of = 7'b1000100;
            default: lamp_of = 7'b1001001;
        endcase
    endfunction

    function automatic int dur(input int p);
        case (p)
            0, 2:    dur = P_TL;
            1, 3:    dur = P_TS;
            default: dur = P_TW;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_pp      = 1'b0;
    endtask

    // One clock edge of the reference, using the inputs held during the cycle.
    task automatic model_step(input bit c, input bit ped, input bit amb);
        bit done;
        int nxt;
        done = (m_elapsed >= dur(m_phase) - 1);
        nxt  = m_phase;
        case (m_phase)
            0: if (done && (c || m_pp) && !amb) nxt = 1;
            1: if (done) nxt = m_pp ? 4 : 2;
            2: if (done || !c || amb) nxt = 3;
            3: if (done) nxt = 0;
            default: if (done || amb) nxt = 0;
        endcase
        if (ped && m_phase != 4)      m_pp = 1'b1;
        else if (m_phase == 4 && done) m_pp = 1'b0;
        m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
        m_phase   = nxt;
    endtask

    // Drive inputs, then compare against the model on the falling edge.
    task automatic sample(input bit c, input bit ped, input bit amb);
        C   = c;
        PED = ped;
        AMB = amb;
        @(negedge Clk);
        check("state", 8'(STATE), 8'(m_phase));
        check("lamps", 8'(lamps), 8'(lamp_of(m_phase)));
        check("pp",    8'(PP),    8'(m_pp));
    endtask

    task automatic advance();
        @(posedge Clk);
        model_step(C, PED, AMB);
        #1;
    endtask

    task automatic cycle(input bit c, input bit ped, input bit amb);
        sample(c, ped, amb);
        advance();
    endtask

    // Asynchronous reset pulse placed between edges; outputs must settle
    // before any clock edge arrives.
    task automatic do_reset();
        reset = 1'b0;
        C     = 1'b0;
        PED   = 1'b0;
        AMB   = 1'b0;
        model_reset();
        #2;
        check("rst_state", 8'(STATE), 8'd0);
        check("rst_lamps", 8'(lamps), 8'(7'b0011000));
        check("rst_pp",    8'(PP),    8'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] es;
        bit         ep;
        bit         c_lvl;
        bit         amb_lvl;

        tbl[0] = '{c: 1'b1, ped: 1'b0, amb: 1'b0, n: 16, st: ST_HG, pp: 1'b0};
        tbl[1] = '{c: 1'b1, ped: 1'b0, amb: 1'b0, n: 4,  st: ST_HY, pp: 1'b0};
        tbl[2] = '{c: 1'b1, ped: 1'b0, amb: 1'b0, n: 16, st: ST_FG, pp: 1'b0};
        tbl[3] = '{c: 1'b1, ped: 1'b0, amb: 1'b0, n: 4,  st: ST_FY, pp: 1'b0};
        tbl[4] = '{c: 1'b1, ped: 1'b0, amb: 1'b0, n: 3,  st: ST_HG, pp: 1'b0};

        reset = 1'b0;
        C     = 1'b0;
        PED   = 1'b0;
        AMB   = 1'b0;
        #1;
        do_reset();

        // Idle intersection stays highway green.
        for (int i = 0; i < 100; i++) begin
            sample(1'b0, 1'b0, 1'b0);
            check("idle", {4'd0, STATE, PP}, 8'd0);
            advance();
        end

        // Continuous farm traffic: full cycle of phase durations.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                sample(tbl[k].c, tbl[k].ped, tbl[k].amb);
                check("tbl_state", 8'(STATE), 8'(tbl[k].st));
                check("tbl_pp",    8'(PP),    8'(tbl[k].pp));
                advance();
            end
        end

        // Single pedestrian pulse at cycle 3 with no farm traffic.
        do_reset();
        for (int i = 0; i < 31; i++) begin
            sample(1'b0, i == 3, 1'b0);
            es = (i < 16) ? ST_HG : (i < 20) ? ST_HY : (i < 28) ? ST_PW : ST_HG;
            ep = (i >= 4) && (i < 28);
            check("ped_state", 8'(STATE), 8'(es));
            check("ped_pp",    8'(PP),    8'(ep));
            check("ped_walk",  8'(WALK),  8'(es == ST_PW));
            advance();
        end

        // Ambulance during farm green, then held through highway green.
        do_reset();
        for (int i = 0; i < 51; i++) begin
            sample(1'b1, 1'b0, i >= 25);
            es = (i < 16) ? ST_HG : (i < 20) ? ST_HY : (i <= 25) ? ST_FG :
                 (i < 30) ? ST_FY : ST_HG;
            check("amb_fg_state", 8'(STATE), 8'(es));
            advance();
        end

        // Ambulance aborts the walk; the walk is served on the next round.
        do_reset();
        for (int i = 0; i < 56; i++) begin
            sample(1'b0, i == 3, i == 22);
            es = (i < 16) ? ST_HG : (i < 20) ? ST_HY : (i < 23) ? ST_PW :
                 (i < 39) ? ST_HG : (i < 43) ? ST_HY : (i < 51) ? ST_PW : ST_HG;
            ep = (i >= 4) && (i < 51);
            check("amb_pw_state", 8'(STATE), 8'(es));
            check("amb_pw_pp",    8'(PP),    8'(ep));
            advance();
        end

        // Reset asserted between edges in the middle of farm yellow.
        do_reset();
        for (int i = 0; i < 39; i++) begin
            sample(1'b1, i == 37, 1'b0);
            if (i == 38) begin
                check("pre_rst_state", 8'(STATE), 8'(ST_FY));
                check("pre_rst_pp",    8'(PP),    8'd1);
            end
            advance();
        end
        do_reset();

        // Random traffic against the reference model.
        c_lvl   = 1'b0;
        amb_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) c_lvl = ~c_lvl;
            if ($urandom_range(0, 39) == 0) amb_lvl = ~amb_lvl;
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cycle(c_lvl, $urandom_range(0, 24) == 0, amb_lvl);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
